// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: operand/result handshake bundle for addsub_pipe
// Operand side: in_valid/in_ready, in_sub, in_a, in_b (in_signed with ADDSUB_PIPE_SAT_EN).
// Result side:  out_valid/out_ready, out_s, out_cout, out_ovf, out_zero, out_neg.
// master = producer of operands / consumer of results, slave = the adder pipeline.
interface addsub_pipe_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic         in_sub;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
`ifdef ADDSUB_PIPE_SAT_EN
  logic         in_signed;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_s;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;
  logic         out_neg;
  modport master (
    output in_valid, in_sub, in_a, in_b, out_ready,
`ifdef ADDSUB_PIPE_SAT_EN
    output in_signed,
`endif
    input  in_ready, out_valid, out_s, out_cout, out_ovf, out_zero, out_neg
  );
  modport slave (
    input  in_valid, in_sub, in_a, in_b, out_ready,
`ifdef ADDSUB_PIPE_SAT_EN
    input  in_signed,
`endif
    output in_ready, out_valid, out_s, out_cout, out_ovf, out_zero, out_neg
  );
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined N-bit adder/subtractor, carry chain split into STAGES registered chunks
// Ports: clock, reset (sync, active high), bus (addsub_pipe_if.slave: operand and result handshakes).
// Optional macro ADDSUB_PIPE_SAT_EN adds in_signed and clamps the result on overflow/carry/borrow.
module addsub_pipe #(
  parameter int N      = 16,
  parameter int STAGES = 2
) (
  input logic          clock,
  input logic          reset,
  addsub_pipe_if.slave bus
);
  localparam int W = N / STAGES;
  logic w_stall;
  assign w_stall      = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~w_stall;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // w_m holds finished sum bits below chunk k and raw A bits from chunk k upward;
    // w_x only keeps the inverted-B bits that are still to be added.
    logic             w_v;
    logic             w_c;
    logic [N-1:0]     w_m;
    logic [N-1:0]     w_o;
    logic [N-1:k*W]   w_x;
    logic [W:0]       w_ch;
`ifdef ADDSUB_PIPE_SAT_EN
    logic             w_sub;
    logic             w_sgn;
`endif
    if (k == 0) begin : g_src
      assign w_v = bus.in_valid;
      assign w_c = bus.in_sub;
      assign w_m = bus.in_a;
      assign w_x = bus.in_b ^ {N{bus.in_sub}};
`ifdef ADDSUB_PIPE_SAT_EN
      assign w_sub = bus.in_sub;
      assign w_sgn = bus.in_signed;
`endif
    end else begin : g_prv
      assign w_v = g_st[k-1].g_reg.r_v;
      assign w_c = g_st[k-1].g_reg.r_c;
      assign w_m = g_st[k-1].g_reg.r_m;
      assign w_x = g_st[k-1].g_reg.r_x;
`ifdef ADDSUB_PIPE_SAT_EN
      assign w_sub = g_st[k-1].g_reg.r_sub;
      assign w_sgn = g_st[k-1].g_reg.r_sgn;
`endif
    end
    assign w_ch = {1'b0, w_m[k*W +: W]} + {1'b0, w_x[k*W +: W]} + {{W{1'b0}}, w_c};
    always_comb begin
      w_o            = w_m;
      w_o[k*W +: W]  = w_ch[W-1:0];
    end
    if (k < STAGES - 1) begin : g_reg
      logic                 r_v;
      logic                 r_c;
      logic [N-1:0]         r_m;
      logic [N-1:(k+1)*W]   r_x;
`ifdef ADDSUB_PIPE_SAT_EN
      logic                 r_sub;
      logic                 r_sgn;
`endif
      always_ff @(posedge clock)
        if (reset) begin
          r_v   <= 1'b0;
          r_c   <= 1'b0;
          r_m   <= '0;
          r_x   <= '0;
`ifdef ADDSUB_PIPE_SAT_EN
          r_sub <= 1'b0;
          r_sgn <= 1'b0;
`endif
        end else if (!w_stall) begin
          r_v <= w_v;
          if (w_v) begin
            r_c   <= w_ch[W];
            r_m   <= w_o;
            r_x   <= w_x[N-1:(k+1)*W];
`ifdef ADDSUB_PIPE_SAT_EN
            r_sub <= w_sub;
            r_sgn <= w_sgn;
`endif
          end
        end
    end else begin : g_out
      // Bit N-1 of w_m is still A[N-1] here because it lives in the last chunk.
      logic         w_cout;
      logic         w_ovf;
      logic [N-1:0] w_f;
      logic         r_v;
      logic [N-1:0] r_s;
      logic         r_cout;
      logic         r_ovf;
      logic         r_zero;
      logic         r_neg;
      assign w_cout = w_ch[W];
      assign w_ovf  = (w_m[N-1] == w_x[N-1]) && (w_o[N-1] != w_m[N-1]);
`ifdef ADDSUB_PIPE_SAT_EN
      assign w_f = (w_sgn & w_ovf)           ? (w_m[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) :
                   (~w_sgn & ~w_sub & w_cout) ? {N{1'b1}} :
                   (~w_sgn & w_sub & ~w_cout) ? {N{1'b0}} : w_o;
`else
      assign w_f = w_o;
`endif
      always_ff @(posedge clock)
        if (reset) begin
          r_v    <= 1'b0;
          r_s    <= '0;
          r_cout <= 1'b0;
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
          r_neg  <= 1'b0;
        end else if (!w_stall) begin
          r_v <= w_v;
          if (w_v) begin
            r_s    <= w_f;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
            r_zero <= ~|w_f;
            r_neg  <= w_f[N-1];
          end
        end
      assign bus.out_valid = r_v;
      assign bus.out_s     = r_s;
      assign bus.out_cout  = r_cout;
      assign bus.out_ovf   = r_ovf;
      assign bus.out_zero  = r_zero;
      assign bus.out_neg   = r_neg;
    end
  end
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined N-bit adder/subtractor with valid/ready handshake, status flags and optional saturation.
- Successor to the team's combinational ripple add/sub. Carry chain is cut into STAGES registered chunks so wide datapaths meet timing at the system clock.
- Used by sprite/scroll position arithmetic: coordinate offsets, camera deltas, bounds checks.

Parameters:
- N, 16, operand/result width in bits. Must be ≥ 2.
- STAGES, 2, number of pipeline stages (carry-chain chunks). Must divide N exactly; chunk width W = N/STAGES.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit accepts a beat this cycle.
- in_sub  input  1  0 = A+B, 1 = A−B.
- in_a  input  N  operand A.
- in_b  input  N  operand B.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- out_s  output  N  result.
- out_cout  output  1  carry out. For subtract: 1 = no borrow (A ≥ B unsigned).
- out_ovf  output  1  two's-complement signed overflow.
- out_zero  output  1  out_s == 0.
- out_neg  output  1  out_s[N-1].

Behaviour:
- Arithmetic:
  - S = A + (B XOR {N{sub}}) + sub, modulo 2^N.
  - cout = carry out of bit N-1.
  - ovf = (A[N-1] == X[N-1]) && (S[N-1] != A[N-1]), where X = B XOR {N{sub}}.
- Pipeline:
  - Stage k (0..STAGES-1) adds chunk k (bits k·W+W-1 .. k·W) using the carry registered by stage k-1. Stage 0 uses carry-in = sub.
  - Completed lower chunks and not-yet-processed upper operand chunks (already XORed with sub) travel with the beat in registers.
  - Each stage holds a valid bit.
- Latency: exactly STAGES cycles from accept (in_valid && in_ready) to out_valid, when there is no stall.
- Throughput: 1 beat/cycle.
- Flags: computed in the final stage from the full registered result. They are presented together with out_s and stay stable while out_valid && !out_ready.
- Handshake:
  - Global stall = out_valid && !out_ready.
  - in_ready = !stall. While stalled, every stage register holds and no beat is accepted.
  - When not stalled, all stages advance. A bubble (in_valid=0) propagates as valid=0.
  - out_s and flags must not change while out_valid=1 and out_ready=0.
- Ordering: results leave in acceptance order. No beat is dropped or duplicated.
- Reset:
  - All stage valid bits, out_valid, out_s, out_cout, out_ovf, out_zero and out_neg are 0 on the cycle after reset is sampled high.
  - in_ready is 1 out of reset.
  - In-flight beats are discarded.
  - Any beat presented during the reset cycle is not accepted.
- Boundary cases:
  - STAGES=1 is a single registered adder with latency 1.
  - STAGES=N gives 1-bit chunks and must work.
  - in_valid while stalled: the beat is held by the source and not accepted.
  - out_ready high with out_valid low: no effect.

Optional Feature:
- Macro ADDSUB_PIPE_SAT_EN.
- Defined:
  - Adds port in_signed (input, 1), which travels with the beat.
  - Final stage clamps out_s:
    - Signed mode, ovf=1: result becomes {1'b0,{N-1{1'b1}}} if A[N-1]=0, otherwise {1'b1,{N-1{1'b0}}}.
    - Unsigned add with cout=1: result becomes all ones.
    - Unsigned subtract with cout=0: result becomes all zeros.
  - out_cout and out_ovf report the unsaturated condition.
  - out_zero and out_neg reflect the clamped out_s.
- Undefined: port in_signed is absent and the result wraps modulo 2^N.

Test Plan:
- N=8, STAGES=2: add 7F+01 → out_s=80, cout=0, ovf=1, neg=1, zero=0; out_valid rises exactly 2 cycles after accept.
- Sub 05−05 → out_s=00, cout=1, ovf=0, zero=1. Sub 03−05 → out_s=FE, cout=0, neg=1, ovf=0.
- Back-pressure: 4 consecutive beats (10+01, 20+02, 30+03, 40+04); out_ready low for 3 cycles after the first result → in_ready low during the stall, outputs held, results 11, 22, 33, 44 in order with none lost.
- Reset asserted with 2 beats in flight → next cycle out_valid=0, all outputs 0, in_ready=1; following beat FF+01 → out_s=00, cout=1, zero=1.
- Parameter sweep: N=16 with STAGES ∈ {1, 4, 16}, 1000 random back-to-back beats with random out_ready → every result matches the reference model and latency equals STAGES when not stalled.
- ADDSUB_PIPE_SAT_EN: FF+01 unsigned → FF (cout=1); 7F+01 signed → 7F (ovf=1); 80−01 signed → 80; 02−05 unsigned → 00 (cout=0).
